// File: rtl/fpu_pkg.sv
// Shared FPU package: IEEE-754 single-precision field layout, constants and
// the special-case operand classifier used by fsquare, fsqrt and later units.
package fpu_pkg;

    localparam int EXP_BIAS = 127;
    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    typedef struct packed {
        logic                s;
        logic [EXP_W-1:0]    e;
        logic [FRAC_W-1:0]   f;
    } float32_t;

    typedef enum logic [1:0] {
        NORM = 2'd0,
        ZERO = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fclass_t;

    // Zero and denormals share one class: both are flushed to zero.
    function automatic fclass_t classify(input float32_t v);
        fclass_t c;
        if (v.e == 8'h00) begin
            c = ZERO;
        end else if (v.e == 8'hFF) begin
            if (v.f != 23'd0) begin
                c = NAN;
            end else begin
                c = INF;
            end
        end else begin
            c = NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fsquare_mul24.sv
// mul24: registered 24x24 -> 48 unsigned multiplier with valid pass-through.
// Kept as its own block so retiming or a two-stage split stays local here.
module mul24 (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic        out_valid,
    output logic [47:0] p
);

    logic        valid_q;
    logic [47:0] p_q;
    logic [47:0] p_d;

    // Full-width unsigned product of the two mantissas.
    always_comb begin
        p_d = 48'd0;
        p_d = {24'd0, a} * {24'd0, b};
    end

    // Product register; only loads on valid operands so idle cycles do not toggle it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            p_q     <= 48'd0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                p_q <= p_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign p         = p_q;

endmodule

// File: rtl/fsquare.sv
// fsquare: 3-stage pipelined single-precision squarer, y = x*x.
//   S1 classify and register operand, S2 mantissa product (mul24),
//   S3 normalize, round, range-check and pack into registered outputs.
// Build option: define FSQUARE_RNE_EN for round-to-nearest-even; otherwise
// the mantissa is truncated and S3 has no increment logic.
module fsquare
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] x,
    output logic        out_valid,
    output logic [31:0] y,
    output logic        ovf,
    output logic        udf
);

    // ---------------- Stage 1 ----------------
    float32_t    x_s;
    fclass_t     cls1_d;
    logic [23:0] m1_d;
    logic        v1_q;
    fclass_t     cls1_q;
    logic [7:0]  e1_q;
    logic [23:0] m1_q;
    logic        unused_sign_s;

    // Unpack the operand and classify it; the sign never reaches the result.
    always_comb begin
        x_s           = float32_t'(x);
        cls1_d        = classify(x_s);
        m1_d          = {1'b1, x_s.f};
        unused_sign_s = x_s.s;
    end

    // Stage-1 register: valid bit always tracks, payload loads on valid only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q   <= 1'b0;
            cls1_q <= ZERO;
            e1_q   <= 8'd0;
            m1_q   <= 24'd0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                cls1_q <= cls1_d;
                e1_q   <= x_s.e;
                m1_q   <= m1_d;
            end
        end
    end

    // ---------------- Stage 2 ----------------
    logic        v2_s;
    logic [47:0] p2_s;
    fclass_t     cls2_q;
    logic [7:0]  e2_q;

    mul24 u_mul24 (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (v1_q),
        .a         (m1_q),
        .b         (m1_q),
        .out_valid (v2_s),
        .p         (p2_s)
    );

    // Class and exponent ride alongside the product so they line up in S3.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cls2_q <= ZERO;
            e2_q   <= 8'd0;
        end else begin
            if (v1_q) begin
                cls2_q <= cls1_q;
                e2_q   <= e1_q;
            end
        end
    end

    // ---------------- Stage 3 ----------------
    logic signed [9:0] exp_n_s;
    logic signed [9:0] exp_r_s;
    logic [22:0]       mant_n_s;
    logic [22:0]       mant_r_s;
    logic [31:0]       y_d;
    logic              ovf_d;
    logic              udf_d;
`ifdef FSQUARE_RNE_EN
    logic              guard_s;
    logic              sticky_s;
    logic              inc_s;
    logic [23:0]       rnd_s;
`else
    logic              unused_lsb_s;
`endif

    // Normalize: the product of two [1,2) mantissas lies in [1,4), so p[47]
    // selects a one-bit shift and bumps the exponent (2e - bias, plus carry).
    always_comb begin
        exp_n_s = $signed({1'b0, e2_q, 1'b0}) - 10'sd127 + $signed({9'd0, p2_s[47]});
        if (p2_s[47]) begin
            mant_n_s = p2_s[46:24];
        end else begin
            mant_n_s = p2_s[45:23];
        end
`ifdef FSQUARE_RNE_EN
        if (p2_s[47]) begin
            guard_s  = p2_s[23];
            sticky_s = |p2_s[22:0];
        end else begin
            guard_s  = p2_s[22];
            sticky_s = |p2_s[21:0];
        end
`else
        unused_lsb_s = ^p2_s[22:0];
`endif
    end

    // Round the mantissa; a carry-out wraps it to zero and bumps the exponent.
    always_comb begin
`ifdef FSQUARE_RNE_EN
        inc_s = guard_s & (sticky_s | mant_n_s[0]);
        rnd_s = {1'b0, mant_n_s} + {23'd0, inc_s};
        if (rnd_s[23]) begin
            mant_r_s = 23'd0;
            exp_r_s  = exp_n_s + 10'sd1;
        end else begin
            mant_r_s = rnd_s[22:0];
            exp_r_s  = exp_n_s;
        end
`else
        mant_r_s = mant_n_s;
        exp_r_s  = exp_n_s;
`endif
    end

    // Select the special-case result or the range-checked normal result.
    always_comb begin
        y_d   = 32'd0;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        case (cls2_q)
            ZERO: begin
                y_d = 32'd0;
            end
            NAN: begin
                y_d = QNAN;
            end
            INF: begin
                y_d = PINF;
            end
            NORM: begin
                if (exp_r_s >= 10'sd255) begin
                    y_d   = PINF;
                    ovf_d = 1'b1;
                end else if (exp_r_s <= 10'sd0) begin
                    y_d   = 32'd0;
                    udf_d = 1'b1;
                end else begin
                    y_d = {1'b0, exp_r_s[7:0], mant_r_s};
                end
            end
            default: begin
                y_d = 32'd0;
            end
        endcase
    end

    logic        out_valid_q;
    logic [31:0] y_q;
    logic        ovf_q;
    logic        udf_q;

    // Output register: result and flags update only with a valid result, else hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            y_q         <= 32'd0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            out_valid_q <= v2_s;
            if (v2_s) begin
                y_q   <= y_d;
                ovf_q <= ovf_d;
                udf_q <= udf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;

endmodule
